// File: rtl/ula_pkg.sv
// Shared types for the sequential ULA: opcode encodings, FSM states and
// the opcode legality check. Macro ULA_MUL_EN enables the MUL opcode.
package ula_pkg;

  // Legacy ULA opcode encodings
  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_NOT = 4'b0001,
    OP_AND = 4'b0010,
    OP_XOR = 4'b0011,
    OP_SUB = 4'b0100,
    OP_SHL = 4'b0101,
    OP_OR  = 4'b0110,
    OP_SHR = 4'b0111,
    OP_MUL = 4'b1000
  } ula_op_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    MUL,
    FIN
  } ula_state_t;

  // Every 0xxx code is a legal op; 1000 only when the multiplier is built in
  function automatic logic is_legal(input logic [3:0] op);
`ifdef ULA_MUL_EN
    return (op[3] == 1'b0) || (op == OP_MUL);
`else
    return op[3] == 1'b0;
`endif
  endfunction

endpackage

// File: rtl/ula_comb.sv
// Single-cycle combinational datapath: ADD/SUB/AND/OR/XOR/NOT with carry
// (or borrow) and signed overflow. Shift and multiply are handled by the top.
module ula_comb
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  ula_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned W1 = WIDTH + 1;
  localparam int unsigned M  = WIDTH - 1;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] dif;

  // Extra top bit carries out of ADD and flags a borrow for SUB
  assign sum = {1'b0, a} + {1'b0, b} + W1'(cin);
  assign dif = {1'b0, a} - {1'b0, b} - W1'(cin);

  // Per-opcode result select
  always_comb begin
    s    = '0;
    cout = 1'b0;
    ovf  = 1'b0;
    case (op)
      OP_ADD: begin
        s    = sum[WIDTH-1:0];
        cout = sum[WIDTH];
        ovf  = (a[M] == b[M]) && (sum[M] != a[M]);
      end
      OP_SUB: begin
        s    = dif[WIDTH-1:0];
        cout = dif[WIDTH];
        ovf  = (a[M] != b[M]) && (dif[M] != a[M]);
      end
      OP_AND: s = a & b;
      OP_OR:  s = a | b;
      OP_XOR: s = a ^ b;
      OP_NOT: begin
        s    = ~a;
        cout = 1'b1;  // legacy ULA behaviour
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ula_seq.sv
// Registered ULA with START/BUSY/DONE handshake. Single-cycle ops finish
// in one cycle; shifts iterate one bit per cycle; MUL (macro ULA_MUL_EN)
// is a shift-add over WIDTH cycles.
module ula_seq
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [3:0]       X,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] S_HI,
  output logic             COUT,
  output logic             ZERO,
  output logic             NEG,
  output logic             OVF,
  output logic             ERR
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam logic [SHW:0] CntOne = 1;

  ula_state_t       state;
  ula_op_t          op_q;
  ula_op_t          op_in;
  logic [WIDTH-1:0] acc;
  logic [SHW:0]     cnt;
  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] c_s, one_s, sh_s;
  logic             c_cout, c_ovf, one_cout, one_ovf, one_err, sh_out, is_shift;

  assign op_in    = ula_op_t'(X);
  assign amt      = B[SHW-1:0];
  assign is_shift = (op_in == OP_SHL) || (op_in == OP_SHR);
  assign BUSY     = (state == SHIFT) || (state == MUL);

  ula_comb #(.WIDTH(WIDTH)) u_comb (
    .op   (op_in),
    .a    (A),
    .b    (B),
    .cin  (CIN),
    .s    (c_s),
    .cout (c_cout),
    .ovf  (c_ovf)
  );

  // Result of an op that completes at the accepting edge
  always_comb begin
    one_s    = c_s;
    one_cout = c_cout;
    one_ovf  = c_ovf;
    one_err  = 1'b0;
    if (!is_legal(X)) begin
      one_s    = '0;
      one_cout = 1'b0;
      one_ovf  = 1'b0;
      one_err  = 1'b1;
    end else if (is_shift) begin
      // zero-amount shift: pass-through, nothing shifted out
      one_s    = A;
      one_cout = 1'b0;
      one_ovf  = 1'b0;
    end
  end

  // One-bit shift step on the working register
  always_comb begin
    if (op_q == OP_SHL) begin
      sh_s   = {acc[WIDTH-2:0], 1'b0};
      sh_out = acc[WIDTH-1];
    end else begin
      sh_s   = {1'b0, acc[WIDTH-1:1]};
      sh_out = acc[0];
    end
  end

`ifdef ULA_MUL_EN
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] s_hi_q;
  logic [WIDTH:0]   mul_sum;
  // acc holds the multiplier and collects low product bits as it shifts out
  assign mul_sum = {1'b0, hi} + (acc[0] ? {1'b0, mcand} : '0);
  assign S_HI    = s_hi_q;
`else
  assign S_HI = '0;
`endif

  // Control FSM, iteration registers and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      op_q  <= OP_ADD;
      acc   <= '0;
      cnt   <= '0;
      DONE  <= 1'b0;
      S     <= '0;
      COUT  <= 1'b0;
      ZERO  <= 1'b0;
      NEG   <= 1'b0;
      OVF   <= 1'b0;
      ERR   <= 1'b0;
`ifdef ULA_MUL_EN
      hi     <= '0;
      mcand  <= '0;
      s_hi_q <= '0;
`endif
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE, FIN: begin
          state <= IDLE;
          if (START) begin
            op_q <= op_in;
            acc  <= A;
            if (is_legal(X) && is_shift && (amt != '0)) begin
              state <= SHIFT;
              cnt   <= {1'b0, amt};
`ifdef ULA_MUL_EN
            end else if (op_in == OP_MUL) begin
              state <= MUL;
              cnt   <= (SHW + 1)'(WIDTH);
              acc   <= B;
              mcand <= A;
              hi    <= '0;
`endif
            end else begin
              state <= FIN;
              DONE  <= 1'b1;
              S     <= one_s;
              COUT  <= one_cout;
              ZERO  <= (one_s == '0);
              NEG   <= one_s[WIDTH-1];
              OVF   <= one_ovf;
              ERR   <= one_err;
`ifdef ULA_MUL_EN
              s_hi_q <= '0;
`endif
            end
          end
        end
        SHIFT: begin
          acc <= sh_s;
          cnt <= cnt - CntOne;
          if (cnt == CntOne) begin
            state <= FIN;
            DONE  <= 1'b1;
            S     <= sh_s;
            COUT  <= sh_out;
            ZERO  <= (sh_s == '0);
            NEG   <= sh_s[WIDTH-1];
            OVF   <= 1'b0;
            ERR   <= 1'b0;
`ifdef ULA_MUL_EN
            s_hi_q <= '0;
`endif
          end
        end
`ifdef ULA_MUL_EN
        MUL: begin
          hi  <= mul_sum[WIDTH:1];
          acc <= {mul_sum[0], acc[WIDTH-1:1]};
          cnt <= cnt - CntOne;
          if (cnt == CntOne) begin
            state  <= FIN;
            DONE   <= 1'b1;
            S      <= {mul_sum[0], acc[WIDTH-1:1]};
            s_hi_q <= mul_sum[WIDTH:1];
            COUT   <= 1'b0;
            ZERO   <= ({mul_sum[0], acc[WIDTH-1:1]} == '0);
            NEG    <= mul_sum[0] & (WIDTH == 1);
            OVF    <= 1'b0;
            ERR    <= 1'b0;
            if (WIDTH > 1) NEG <= mul_sum[0];
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// Self-checking bench for ula_seq (WIDTH=8): directed test-plan steps plus
// randomized ops checked against an arithmetic reference model.
module tb_ula_seq;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic [3:0] X = 4'h0;
  logic [7:0] A = 8'h00, B = 8'h00;
  logic       CIN = 1'b0;
  logic       BUSY, DONE, COUT, ZERO, NEG, OVF, ERR;
  logic [7:0] S, S_HI;

  int checks = 0;
  int errors = 0;

`ifdef ULA_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  logic [7:0] e_s, e_shi;
  logic       e_cout, e_ovf, e_err;
  int         e_lat;

  ula_seq #(.WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .START(START), .X(X), .A(A), .B(B), .CIN(CIN),
    .BUSY(BUSY), .DONE(DONE), .S(S), .S_HI(S_HI), .COUT(COUT), .ZERO(ZERO),
    .NEG(NEG), .OVF(OVF), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model from the opcode rules, using plain integer arithmetic
  task automatic model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic cin);
    int t, n, sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    n  = int'(b[2:0]);
    e_s = 8'h00; e_shi = 8'h00; e_cout = 1'b0; e_ovf = 1'b0; e_err = 1'b0; e_lat = 1;
    case (op)
      4'b0000: begin
        t = int'(a) + int'(b) + int'(cin);
        e_s = t[7:0]; e_cout = (t > 255);
        e_ovf = ((sa + sb + int'(cin)) > 127) || ((sa + sb + int'(cin)) < -128);
      end
      4'b0100: begin
        t = int'(a) - int'(b) - int'(cin);
        e_s = t[7:0]; e_cout = (t < 0);
        e_ovf = ((sa - sb - int'(cin)) > 127) || ((sa - sb - int'(cin)) < -128);
      end
      4'b0010: e_s = a & b;
      4'b0110: e_s = a | b;
      4'b0011: e_s = a ^ b;
      4'b0001: begin e_s = ~a; e_cout = 1'b1; end
      4'b0101: begin
        t = int'(a) << n; e_s = t[7:0];
        if (n > 0) begin t = (int'(a) >> (8 - n)) & 1; e_cout = t[0]; end
        e_lat = n + 1;
      end
      4'b0111: begin
        t = int'(a) >> n; e_s = t[7:0];
        if (n > 0) begin t = (int'(a) >> (n - 1)) & 1; e_cout = t[0]; end
        e_lat = n + 1;
      end
      4'b1000: begin
        if (MulEn) begin
          t = int'(a) * int'(b); e_s = t[7:0]; e_shi = t[15:8]; e_lat = 9;
        end else e_err = 1'b1;
      end
      default: e_err = 1'b1;
    endcase
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".s"}, 32'(S), 32'(e_s));
    check({tag, ".s_hi"}, 32'(S_HI), 32'(e_shi));
    check({tag, ".cout"}, 32'(COUT), 32'(e_cout));
    check({tag, ".zero"}, 32'(ZERO), 32'(e_s == 8'h00));
    check({tag, ".neg"}, 32'(NEG), 32'(e_s[7]));
    check({tag, ".ovf"}, 32'(OVF), 32'(e_ovf));
    check({tag, ".err"}, 32'(ERR), 32'(e_err));
  endtask

  // Issue one op; optionally fire an ignored START during the first BUSY cycle
  task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic cin, input bit poke);
    int c, busy_n;
    model(op, a, b, cin);
    X = op; A = a; B = b; CIN = cin; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    // scramble inputs so results must come from captured values
    X = 4'(op + 4'd1); A = 8'($urandom); B = 8'($urandom); CIN = ~cin;
    c = 1; busy_n = 0;
    while (!DONE && c <= 40) begin
      if (BUSY) busy_n++;
      START = (poke && BUSY && c == 1);
      @(posedge CLK); #1;
      c++;
    end
    START = 1'b0;
    check({tag, ".latency"}, 32'(c), 32'(e_lat));
    check({tag, ".busy_cycles"}, 32'(busy_n), 32'(e_lat - 1));
    check({tag, ".busy_at_done"}, 32'(BUSY), 32'd0);
    check_outputs(tag);
  endtask

  // Results hold and DONE drops after the completing cycle
  task automatic hold_check(input string tag);
    @(posedge CLK); #1;
    check({tag, ".done_pulse"}, 32'(DONE), 32'd0);
    @(posedge CLK); #1;
    check_outputs({tag, ".hold"});
  endtask

  initial begin
    // Reset state
    @(posedge CLK); #1;
    check("rst.busy", 32'(BUSY), 32'd0);
    check("rst.done", 32'(DONE), 32'd0);
    check("rst.outs", 32'({S, S_HI, COUT, ZERO, NEG, OVF, ERR}), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;

    run_op("add_ff_01", 4'b0000, 8'hFF, 8'h01, 1'b0, 1'b0);
    hold_check("add_ff_01");
    run_op("sub_80_01", 4'b0100, 8'h80, 8'h01, 1'b0, 1'b0);
    run_op("shl_e1_3", 4'b0101, 8'hE1, 8'h03, 1'b0, 1'b1);
    check("shl_e1_3.s_lit", 32'(S), 32'h08);
    hold_check("shl_e1_3");
    run_op("mul_ff_ff", 4'b1000, 8'hFF, 8'hFF, 1'b0, 1'b1);
    run_op("illegal_f", 4'b1111, 8'h5A, 8'hA5, 1'b1, 1'b0);
    check("illegal_f.err_lit", 32'(ERR), 32'd1);
    run_op("add_after_err", 4'b0000, 8'h12, 8'h34, 1'b0, 1'b0);
    check("add_after_err.err_lit", 32'(ERR), 32'd0);
    run_op("shr_zero_amt", 4'b0111, 8'h81, 8'h08, 1'b0, 1'b0);

    // Reset in the middle of a long op: everything clears, no DONE
    X = MulEn ? 4'b1000 : 4'b0111; A = 8'hC3; B = 8'h07; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("mid_rst.busy_before", 32'(BUSY), 32'd1);
    RST = 1'b1;
    #1;
    check("mid_rst.busy", 32'(BUSY), 32'd0);
    check("mid_rst.outs", 32'({DONE, S, S_HI, COUT, ZERO, NEG, OVF, ERR}), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    check("mid_rst.no_done", 32'(DONE), 32'd0);
    RST = 1'b0;
    repeat (10) begin
      @(posedge CLK); #1;
      check("mid_rst.idle_done", 32'(DONE), 32'd0);
    end
    run_op("after_rst_sub", 4'b0100, 8'h10, 8'h20, 1'b1, 1'b0);

    // Randomized ops, issued back to back
    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      op = (i % 5 == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      if (i % 7 == 0) op = 4'b1000;
      run_op($sformatf("rnd%0d", i), op, 8'($urandom), 8'($urandom), 1'($urandom),
             1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
